// File: rtl/rs232_pkg.sv
// Shared rs232 link definitions: UART FSM states and character constants.
// Used by both the TxD word transmitter and the RxD receiver path.
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } uart_state_t;

  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam int         UART_DATA_BITS = 8;
  localparam int         WORD_BITS      = 32;

endpackage

// File: rtl/ascii_word_tx_if.sv
// Host-side bus of the word transmitter: word load/start request, busy/done status, serial line.
interface ascii_word_tx_if;
  import rs232_pkg::*;

  logic                 start;
  logic [WORD_BITS-1:0] data_in;
  logic                 txd;
  logic                 busy;
  logic                 done;

  modport master (output start, data_in, input txd, busy, done);
  modport slave  (input start, data_in, output txd, busy, done);

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 serializer for one byte: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT clk each.
// A byte offered during the last stop-bit cycle starts its start bit on the next edge, with no idle gap.
module uart_tx_byte
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       frame_end,
  output logic       txd
);

  uart_state_t state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        bit_end;

  assign bit_end    = (baud_cnt == 16'(CLKS_PER_BIT - 1));
  assign frame_end  = (state == STOP) && bit_end;
  assign byte_ready = (state == IDLE) || frame_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else if (byte_valid && byte_ready) begin
      state    <= START;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= byte_data;
      txd      <= 1'b0;
    end else if (state == IDLE) begin
      baud_cnt <= '0;
      txd      <= 1'b1;
    end else if (!bit_end) begin
      baud_cnt <= baud_cnt + 16'd1;
    end else begin
      baud_cnt <= '0;
      case (state)
        START: begin
          state <= DATA;
          txd   <= shift[0];
          shift <= shift >> 1;
        end
        DATA: begin
          if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
            state <= STOP;
            txd   <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            txd     <= shift[0];
            shift   <= shift >> 1;
          end
        end
        default: begin
          // End of stop bit with nothing offered: back to idle line.
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ascii_word_tx.sv
// Sends a latched 32-bit word as four 8N1 characters, MSB byte first; busy for the whole word, done pulse after.
// Optional ASCII_TX_CRLF_EN appends CR LF frames. Starts are accepted only in IDLE (never in the done cycle).
module ascii_word_tx
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int NUM_BYTES    = 4
) (
  input  logic            clk,
  input  logic            rst,
  ascii_word_tx_if.slave  bus
);

`ifdef ASCII_TX_CRLF_EN
  localparam int TOTAL_BYTES = NUM_BYTES + 2;
`else
  localparam int TOTAL_BYTES = NUM_BYTES;
`endif
  localparam int CNT_W = $clog2(TOTAL_BYTES + 1);

  // DATA here means "word in flight"; bit-level states live in the serializer.
  uart_state_t          state;
  logic [WORD_BITS-1:0] word_q;
  logic [CNT_W-1:0]     byte_cnt;
  logic                 accept;
  logic                 byte_valid;
  logic                 byte_ready;
  logic                 frame_end;
  logic [7:0]           byte_data;
  logic [7:0]           next_byte;

  assign accept = (state == IDLE) && bus.start;

  always_comb begin
    next_byte = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (byte_cnt == CNT_W'(i)) next_byte = word_q[8*(NUM_BYTES-1-i) +: 8];
    end
`ifdef ASCII_TX_CRLF_EN
    if (byte_cnt == CNT_W'(NUM_BYTES))     next_byte = ASCII_CR;
    if (byte_cnt == CNT_W'(NUM_BYTES + 1)) next_byte = ASCII_LF;
`endif
  end

  // The first byte bypasses word_q so its start bit begins on the edge after accept.
  assign byte_valid = accept || ((state == DATA) && (byte_cnt < CNT_W'(TOTAL_BYTES)));
  assign byte_data  = accept ? bus.data_in[WORD_BITS-1 -: 8] : next_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_q   <= '0;
      byte_cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            word_q   <= bus.data_in;
            byte_cnt <= CNT_W'(1);
            state    <= DATA;
            bus.busy <= 1'b1;
          end
        end
        DATA: begin
          if (frame_end) begin
            if (byte_cnt == CNT_W'(TOTAL_BYTES)) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .frame_end  (frame_end),
    .txd        (bus.txd)
  );

endmodule

// File: tb/tb_ascii_word_tx.sv
// Scoreboarded bench: two transmitters (4 and 2 clk/bit), mid-bit line decoder per instance.
module tb_ascii_word_tx;
  import rs232_pkg::*;

  localparam int C_A = 4;
  localparam int C_B = 2;
`ifdef ASCII_TX_CRLF_EN
  localparam int TOT = 6;
`else
  localparam int TOT = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ascii_word_tx_if bus_a ();
  ascii_word_tx_if bus_b ();

  ascii_word_tx #(.CLKS_PER_BIT(C_A), .NUM_BYTES(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  ascii_word_tx #(.CLKS_PER_BIT(C_B), .NUM_BYTES(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int          n_checks = 0;
  int          n_errors = 0;
  int          gen = 0;
  logic [7:0]  exp_a[$];
  logic [7:0]  exp_b[$];
  bit          cap_req = 1'b0;
  logic [9:0]  cap_bits = '0;
  int          busy_a = 0, busy_b = 0, done_a = 0, done_b = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic line(input int sel);
    return (sel == 0) ? bus_a.txd : bus_b.txd;
  endfunction

  function automatic logic dn(input int sel);
    return (sel == 0) ? bus_a.done : bus_b.done;
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 0) ? exp_a.size() : exp_b.size();
  endfunction

  always @(negedge clk) begin
    if (bus_a.busy === 1'b1) busy_a++;
    if (bus_b.busy === 1'b1) busy_b++;
    if (bus_a.done === 1'b1) done_a++;
    if (bus_b.done === 1'b1) done_b++;
  end

  task automatic push_word(input int sel, input logic [31:0] w);
    logic [7:0] q[$];
    for (int i = 3; i >= 0; i--) q.push_back(w[8*i +: 8]);
`ifdef ASCII_TX_CRLF_EN
    q.push_back(8'h0D);
    q.push_back(8'h0A);
`endif
    foreach (q[k]) begin
      if (sel == 0) exp_a.push_back(q[k]);
      else          exp_b.push_back(q[k]);
    end
  endtask

  task automatic score(input int sel, input logic [9:0] bits);
    logic [7:0] e;
    chk("framing", 32'({bits[9], bits[0]}), 32'(2'b10));
    if (sel == 0 && cap_req) begin
      cap_bits = bits;
      cap_req  = 1'b0;
    end
    if (qsize(sel) == 0) begin
      chk("byte_expected", 32'(qsize(sel)), 32'd1);
    end else begin
      if (sel == 0) e = exp_a.pop_front();
      else          e = exp_b.pop_front();
      chk((sel == 0) ? "byte_a" : "byte_b", 32'(bits[8:1]), 32'(e));
    end
  endtask

  // Line decoder: samples each bit at its middle, checks back-to-back frames within a word.
  task automatic mon(input int sel);
    int         cper;
    int         polls;
    int         g;
    bit         gap_needed;
    logic [9:0] bits;
    cper       = (sel == 0) ? C_A : C_B;
    polls      = 0;
    gap_needed = 1'b0;
    forever begin
      @(negedge clk);
      if (line(sel) === 1'b0 && rst === 1'b0) begin
        if (gap_needed) chk("no_gap", 32'(polls), 32'(cper - cper/2 - 1));
        g = gen;
        repeat (cper/2) @(negedge clk);
        bits[0] = line(sel);
        for (int b = 1; b < 10; b++) begin
          repeat (cper) @(negedge clk);
          bits[b] = line(sel);
        end
        if (g == gen) score(sel, bits);
        polls      = 0;
        gap_needed = (g == gen) && (qsize(sel) != 0);
      end else begin
        polls++;
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  task automatic send(input int sel, input logic [31:0] w);
    if (sel == 0) begin bus_a.start = 1'b1; bus_a.data_in = w; end
    else          begin bus_b.start = 1'b1; bus_b.data_in = w; end
    @(negedge clk);
    bus_a.start   = 1'b0;
    bus_b.start   = 1'b0;
    bus_a.data_in = $urandom;
    bus_b.data_in = $urandom;
  endtask

  task automatic wait_done(input int sel, input int limit);
    int n = 0;
    while (dn(sel) !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(dn(sel)), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int b0, d0;
    bus_a.start = 1'b0; bus_a.data_in = '0;
    bus_b.start = 1'b0; bus_b.data_in = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txd",  32'(bus_a.txd),  32'd1);
    chk("rst_busy", 32'(bus_a.busy), 32'd0);
    chk("rst_done", 32'(bus_a.done), 32'd0);
    chk("rst_txd_b", 32'(bus_b.txd), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single word, first frame captured bit by bit.
    cap_req = 1'b1;
    b0 = busy_a; d0 = done_a;
    push_word(0, 32'h3132_3334);
    send(0, 32'h3132_3334);
    wait_done(0, 2000);
    @(negedge clk);
    chk("busy_cycles_w1", 32'(busy_a - b0), 32'(TOT*10*C_A));
    chk("done_pulses_w1", 32'(done_a - d0), 32'd1);
    chk("first_frame_bits", 32'(cap_bits), 32'(10'b10_0110_0010));
    repeat (5) @(negedge clk);

    // Starts while busy are ignored.
    b0 = busy_a; d0 = done_a;
    push_word(0, 32'h3132_3334);
    send(0, 32'h3132_3334);
    for (int k = 0; k < 3; k++) begin
      repeat (37) @(negedge clk);
      send(0, 32'h3939_3939);
    end
    wait_done(0, 2000);
    @(negedge clk);
    chk("busy_cycles_ign", 32'(busy_a - b0), 32'(TOT*10*C_A));
    chk("done_pulses_ign", 32'(done_a - d0), 32'd1);
    repeat (5) @(negedge clk);

    // Reset 50 cycles into a word aborts it.
    d0 = done_a;
    push_word(0, 32'h3132_3334);
    send(0, 32'h3132_3334);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    gen++;
    @(negedge clk);
    chk("abort_txd",  32'(bus_a.txd),  32'd1);
    chk("abort_busy", 32'(bus_a.busy), 32'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_no_done", 32'(done_a - d0), 32'd0);
    exp_a.delete();

    b0 = busy_a; d0 = done_a;
    push_word(0, 32'h4142_4344);
    send(0, 32'h4142_4344);
    wait_done(0, 2000);
    @(negedge clk);
    chk("busy_cycles_post_rst", 32'(busy_a - b0), 32'(TOT*10*C_A));
    chk("done_pulses_post_rst", 32'(done_a - d0), 32'd1);
    repeat (5) @(negedge clk);

    // start held high: one idle cycle after done, then the next word.
    b0 = busy_a; d0 = done_a;
    push_word(0, 32'h3030_3030);
    bus_a.data_in = 32'h3030_3030;
    bus_a.start   = 1'b1;
    wait_done(0, 2000);
    @(negedge clk);
    chk("idle_gap_busy", 32'(bus_a.busy), 32'd0);
    @(negedge clk);
    chk("restart_busy", 32'(bus_a.busy), 32'd1);
    push_word(0, 32'h3030_3030);
    wait_done(0, 2000);
    bus_a.start = 1'b0;
    @(negedge clk);
    chk("busy_cycles_cont", 32'(busy_a - b0), 32'(2*TOT*10*C_A));
    chk("done_pulses_cont", 32'(done_a - d0), 32'd2);
    @(negedge clk);
    chk("cont_stopped", 32'(bus_a.busy), 32'd0);

    // Fast instance, extreme byte values.
    b0 = busy_b; d0 = done_b;
    push_word(1, 32'h00FF_55AA);
    send(1, 32'h00FF_55AA);
    wait_done(1, 2000);
    @(negedge clk);
    chk("busy_cycles_b", 32'(busy_b - b0), 32'(TOT*10*C_B));
    chk("done_pulses_b", 32'(done_b - d0), 32'd1);

    repeat (20) @(negedge clk);
    chk("queue_a_empty", 32'(exp_a.size()), 32'd0);
    chk("queue_b_empty", 32'(exp_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ascii_word_tx.md
Name: ascii_word_tx

Overview:
- Transmit side of the rs232 link: serializes a 32-bit word of four ASCII characters onto TxD as 8N1 UART frames.
- Host logic loads a word and pulses start; the PC or the receiving board sees four characters, MSB byte first.
- Sits beside the RxD receiver/display path and uses the same byte ordering as the receive-side 32-bit words (byte 3 = [31:24] ... byte 0 = [7:0]).

Parameters:
- CLKS_PER_BIT, default 5208, clk cycles per UART bit (50 MHz / 9600). Legal range 2..65535.
- NUM_BYTES, default 4, characters per word. Fixed at 4 in this revision; sizes the byte counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only while busy=0.
- data_in  input  32  four ASCII bytes; captured on the accepted start cycle.
- txd  output  1  serial line; idles high.
- busy  output  1  high from the cycle after an accepted start until the end of the last stop bit.
- done  output  1  one-cycle pulse when the word (and optional suffix) has finished.

Behaviour:
- Reset: txd=1, busy=0, done=0, FSM=IDLE, baud and bit counters=0, shift register cleared. Reset mid-frame aborts at once: txd=1 on the next edge, no done pulse.
- Accept: start=1 with busy=0 latches data_in into a word register. busy=1 and txd=0 (start bit) on the following edge. start while busy=1 is ignored; data_in is don't-care outside the accept cycle.
- Byte order: [31:24], [23:16], [15:8], [7:0].
- Frame per byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary occurs when the counter equals CLKS_PER_BIT-1.
- FSM states:
  - IDLE: on start, -> START.
  - START: after one bit time, -> DATA.
  - DATA: bit index 0..7; after bit 7, -> STOP.
  - STOP: at end of bit time, -> START if bytes remain, otherwise -> DONE.
  - DONE: one cycle; done=1, busy=0; then -> IDLE.
- Back-to-back bytes: there is no idle gap between the stop bit and the next start bit.
- Total busy duration: NUM_BYTES*10*CLKS_PER_BIT cycles.
- A start asserted in the same cycle as done is ignored, because busy was high at the previous edge. The earliest accepted start is the cycle after done.
- Byte values are not checked; any 8-bit value is sent verbatim, including 0x00.

Optional Feature:
- Macro: ASCII_TX_CRLF_EN.
- Defined: after byte 0, two more frames are sent, 0x0D then 0x0A. Busy duration becomes (NUM_BYTES+2)*10*CLKS_PER_BIT cycles, and done pulses after the LF stop bit.
- Undefined: only the four data bytes are sent, and the suffix logic is absent.

Decomposition:
- Shared package rs232_pkg:
  - FSM state enum: IDLE, START, DATA, STOP, DONE.
  - Constants: ASCII_CR=8'h0D, ASCII_LF=8'h0A, UART_DATA_BITS=8.
  - Shared with the receiver.
- One natural sub-module, uart_tx_byte:
  - Baud counter, bit shifter and txd driver for a single byte.
  - byte_valid/byte_ready handshake.
  - ascii_word_tx keeps the word register, byte sequencing, busy/done and the CRLF suffix.

Test Plan:
- CLKS_PER_BIT=4, data_in=0x31323334, start pulse -> txd samples (mid-bit) for byte 1: 0,1,0,0,0,1,1,0,0,1. Decoded bytes are 0x31,0x32,0x33,0x34; busy high exactly 160 cycles; single done pulse.
- Reset asserted 50 cycles into the above transfer -> txd=1, busy=0 on the next edge; no done; a new start after reset sends a full 4-byte word correctly.
- Second start pulses during busy, with data_in changed to 0x39393939 -> ignored; transmitted bytes remain 0x31..0x34.
- start held high continuously with data_in=0x30303030 -> consecutive words separated by exactly one IDLE cycle after done; each word is 160 busy cycles.
- ASCII_TX_CRLF_EN defined, data_in=0x35363738 -> bytes 0x35,0x36,0x37,0x38,0x0D,0x0A; busy high 240 cycles.
- CLKS_PER_BIT=2, data_in=0x00FF55AA -> frames decode as 0x00,0xFF,0x55,0xAA; no idle gap between the stop and start bits of consecutive bytes.
